// File: rtl/demux8_stream.sv
// One-to-eight stream demultiplexer: each lane is a one-entry buffer that can
// be refilled in the same cycle it drains, plus a count of accepted transfers.
module demux8_stream #(
  parameter int nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [2:0]         in_sel,
  input  logic [nbits-1:0]   in_data,
  output logic [7:0]         out_val,
  input  logic [7:0]         out_rdy,
  output logic [8*nbits-1:0] out_data,
  output logic               busy,
  input  logic               count_clear,
  output logic [nbits-1:0]   accept_count
);

  logic [7:0]       full_q, full_d;
  logic [nbits-1:0] data_q [8];
  logic [nbits-1:0] data_d [8];
  logic [nbits-1:0] count_q, count_d;
  logic             in_xfer_s;

  // A full lane still accepts when it is draining in the same cycle
  assign in_rdy    = ~full_q[in_sel] | out_rdy[in_sel];
  assign in_xfer_s = in_val & in_rdy;

  // Next-state for lane flags and data: drains first, then the selected fill wins
  always_comb begin
    full_d = full_q & ~out_rdy;
    data_d = data_q;
    if (in_xfer_s) begin
      full_d[in_sel] = 1'b1;
      data_d[in_sel] = in_data;
    end else begin
      full_d = full_q & ~out_rdy;
    end
  end

  // Accepted-transfer counter; clear has priority over a simultaneous transfer
  always_comb begin
    count_d = count_q;
    if (count_clear) begin
      count_d = '0;
    end else if (in_xfer_s) begin
      count_d = count_q + {{(nbits-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 8'h00;
      count_q <= '0;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      full_q  <= full_d;
      count_q <= count_d;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Pack lane registers onto the flat output bus
  always_comb begin
    out_data = '0;
    for (int k = 0; k < 8; k++) begin
      out_data[k*nbits +: nbits] = data_q[k];
    end
  end

  assign out_val      = full_q;
  assign busy         = |full_q;
  assign accept_count = count_q;

endmodule

// File: tb/tb_demux8_stream.sv
// Directed bench for demux8_stream: a 32-bit instance for lane behaviour and a
// 4-bit instance for counter wrap.
module tb_demux8_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_val;
  logic         in_rdy;
  logic [2:0]   in_sel;
  logic [31:0]  in_data;
  logic [7:0]   out_val;
  logic [7:0]   out_rdy;
  logic [255:0] out_data;
  logic         busy;
  logic         count_clear;
  logic [31:0]  accept_count;

  logic         in_val4;
  logic         in_rdy4;
  logic [2:0]   in_sel4;
  logic [3:0]   in_data4;
  logic [7:0]   out_val4;
  logic [31:0]  out_data4;
  logic         busy4;
  logic [3:0]   accept_count4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux8_stream #(.nbits(32)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_sel(in_sel),
    .in_data(in_data), .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .busy(busy), .count_clear(count_clear), .accept_count(accept_count)
  );

  demux8_stream #(.nbits(4)) dut4 (
    .clk(clk), .reset(reset), .in_val(in_val4), .in_rdy(in_rdy4), .in_sel(in_sel4),
    .in_data(in_data4), .out_val(out_val4), .out_rdy(8'hFF), .out_data(out_data4),
    .busy(busy4), .count_clear(1'b0), .accept_count(accept_count4)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_val = 1'b0; in_sel = 3'd0; in_data = 32'h0;
    out_rdy = 8'h00; count_clear = 1'b0;
    in_val4 = 1'b0; in_sel4 = 3'd0; in_data4 = 4'h0;
    step(); step();
    reset = 1'b0;
    chk("rst_out_val", out_val, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", accept_count, 32'd0);
    chk("rst_out_data", out_data, 256'd0);

    // Single write to lane 3
    in_val = 1'b1; in_sel = 3'd3; in_data = 32'hA5A5_0003; #1;
    chk("wr3_in_rdy", in_rdy, 1'b1);
    step();
    in_val = 1'b0;
    chk("wr3_out_val", out_val, 8'b0000_1000);
    chk("wr3_data", out_data[3*32 +: 32], 32'hA5A5_0003);
    chk("wr3_busy", busy, 1'b1);
    chk("wr3_count", accept_count, 32'd1);

    // Lane 3 full and stalled: no acceptance
    in_val = 1'b1; in_sel = 3'd3; in_data = 32'hDEAD_BEEF; #1;
    chk("stall_in_rdy", in_rdy, 1'b0);
    step();
    chk("stall_data", out_data[3*32 +: 32], 32'hA5A5_0003);
    chk("stall_count", accept_count, 32'd1);
    chk("stall_out_val", out_val, 8'h08);

    // Refill while draining lane 3
    out_rdy = 8'h08; in_data = 32'h0000_0BEE; #1;
    chk("pass_in_rdy", in_rdy, 1'b1);
    in_val = 1'b0; #1;
    chk("rdy_indep_val", in_rdy, 1'b1);
    in_val = 1'b1;
    step();
    in_val = 1'b0;
    chk("pass_out_val", out_val, 8'h08);
    chk("pass_data", out_data[3*32 +: 32], 32'h0000_0BEE);
    chk("pass_count", accept_count, 32'd2);
    step();
    out_rdy = 8'h00;
    chk("drain3_out_val", out_val, 8'h00);
    chk("drain3_busy", busy, 1'b0);

    // Fill all eight lanes, then drain them together
    for (int i = 0; i < 8; i++) begin
      in_val = 1'b1; in_sel = 3'(i); in_data = 32'h10 + 32'(i);
      step();
    end
    in_val = 1'b0;
    chk("fill_out_val", out_val, 8'hFF);
    chk("fill_count", accept_count, 32'd10);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fill_lane%0d", i), out_data[i*32 +: 32], 32'h10 + 32'(i));
    end
    out_rdy = 8'hFF;
    step();
    out_rdy = 8'h00;
    chk("drain_out_val", out_val, 8'h00);
    chk("drain_busy", busy, 1'b0);

    // Clear beats a simultaneous transfer, data still captured
    count_clear = 1'b1; in_val = 1'b1; in_sel = 3'd0; in_data = 32'h77;
    step();
    count_clear = 1'b0; in_val = 1'b0;
    chk("clr_count", accept_count, 32'd0);
    chk("clr_data", out_data[31:0], 32'h77);
    chk("clr_out_val", out_val, 8'h01);
    out_rdy = 8'h01;
    step();
    out_rdy = 8'h00;

    // Lanes 1 and 6 full, then reset with a transfer attempt
    in_val = 1'b1; in_sel = 3'd1; in_data = 32'h11; step();
    in_sel = 3'd6; in_data = 32'h66; step();
    chk("l16_out_val", out_val, 8'h42);
    chk("l16_count", accept_count, 32'd2);
    reset = 1'b1; in_sel = 3'd2; in_data = 32'h55;
    step();
    reset = 1'b0; in_val = 1'b0;
    chk("mid_rst_out_val", out_val, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_count", accept_count, 32'd0);
    chk("mid_rst_data", out_data, 256'd0);

    // 4-bit counter wrap
    for (int i = 0; i < 15; i++) begin
      in_val4 = 1'b1; in_sel4 = 3'(i % 8); in_data4 = 4'(i);
      step();
    end
    chk("wrap_pre", accept_count4, 4'd15);
    step();
    in_val4 = 1'b0;
    chk("wrap_zero", accept_count4, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux8_stream.md
DEMUX8_STREAM -- requirements
Module: demux8_stream

Interface
REQ-001 The block SHALL have one parameter: nbits, default 32, the data width of every lane.
REQ-002 The block SHALL have the following ports, in this order:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- in_val  input  1  input transfer valid
- in_rdy  output  1  input transfer ready
- in_sel  input  3  destination lane index 0..7
- in_data  input  nbits  input payload
- out_val  output  8  per-lane valid; bit k is lane k
- out_rdy  input  8  per-lane ready; bit k is lane k
- out_data  output  8*nbits  per-lane payload; lane k occupies bits [k*nbits +: nbits]
- busy  output  1  high when any lane holds data
- count_clear  input  1  synchronous clear of accept_count
- accept_count  output  nbits  number of accepted input transfers
REQ-003 The clock port SHALL be clk, and the reset port SHALL be reset; reset is synchronous and active-high.

Function
REQ-004 An input transfer SHALL occur in a cycle when in_val && in_rdy are both high at the rising edge of clk.
REQ-005 A lane-k output transfer SHALL occur in a cycle when out_val[k] && out_rdy[k] are both high at the rising edge of clk.
REQ-006 Each lane SHALL be a one-entry buffer with a full flag and a data register of nbits.
REQ-007 out_val[k] SHALL equal the lane-k full flag, and the lane-k slice of out_data SHALL equal the lane-k data register.
REQ-008 in_rdy SHALL equal (~full[in_sel]) | out_rdy[in_sel], computed combinationally.
- in_rdy therefore has a combinational path from in_sel and out_rdy.
- in_rdy SHALL NOT depend on in_val.
REQ-009 On an input transfer, the lane selected by in_sel SHALL capture in_data and SHALL set its full flag; no other lane's data register SHALL change.
REQ-010 Latency from input transfer to out_val[k] high SHALL be exactly 1 cycle.
REQ-011 There SHALL be no combinational path from in_data to out_data.
REQ-012 On a lane-k output transfer with no simultaneous input transfer to lane k, full[k] SHALL clear next cycle.
REQ-013 When an output transfer and an input transfer hit the same lane in the same cycle, the lane SHALL stay full and SHALL hold the new in_data, with no bubble and no loss.
REQ-014 Lanes SHALL be independent: any set of lanes may drain in the same cycle, concurrently with one input transfer to any lane.
REQ-015 While out_val[k] is high and out_rdy[k] is low, the lane-k data register SHALL hold its value.
REQ-016 busy SHALL equal the OR of all eight full flags.
REQ-017 accept_count SHALL increment by 1 on each input transfer and SHALL wrap modulo 2^nbits.
- If count_clear is high, accept_count SHALL become 0 next cycle.
- count_clear SHALL take priority over a simultaneous input transfer; that transfer is not counted, but its data is still captured.
REQ-018 in_sel values SHALL always be 0..7; all 3-bit values are legal, and no lane is reserved.

Reset
REQ-019 While reset is high at a clock edge, all full flags, all data registers and accept_count SHALL become 0.
- Consequently out_val = 8'h00, out_data = 0, busy = 0 and accept_count = 0 in the following cycle.
REQ-020 Reset SHALL take priority over any simultaneous input transfer, output transfer or count_clear.
- A transfer attempted in the reset cycle SHALL be discarded and not counted.
REQ-021 Reset asserted mid-operation with lanes full SHALL drop all buffered data, with no output transfer after reset.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset, then in_val=1, in_sel=3, in_data=32'hA5A5_0003, out_rdy=0 -> next cycle out_val=8'b0000_1000, lane-3 data=32'hA5A5_0003, busy=1, accept_count=1.
- Lane 3 full, out_rdy=0, in_val=1, in_sel=3 -> in_rdy=0; lane-3 data unchanged; accept_count unchanged.
- Lane 3 full, out_rdy[3]=1, in_val=1, in_sel=3, in_data=32'h0000_0BEE -> in_rdy=1; lane 3 remains full with 32'h0000_0BEE; accept_count increments.
- Write lanes 0..7 with values 0x10..0x17 and out_rdy=0, then out_rdy=8'hFF for one cycle -> out_val=8'hFF with the correct per-lane data, then 8'h00 and busy=0.
- accept_count preloaded to 2^nbits-1 via transfers (nbits=4: 15 transfers), one more transfer -> accept_count=0.
- Same cycle: count_clear=1 and an input transfer -> accept_count=0 and the data is captured.
- Lanes 1 and 6 full, reset=1 with in_val=1 -> next cycle out_val=0, busy=0, accept_count=0.
